// File: rtl/key_light_pkg.sv
// Shared definitions for the key light driver: channel state encoding,
// default silence code and brightness ceiling helper.
package key_light_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HOLD    = 2'd2,
    FADE    = 2'd3
  } chan_state_t;

  localparam int unsigned REST_CODE_DEFAULT = 99;

  function automatic int unsigned bright_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/key_light_channel.sv
// One key light: press/hold/fade state machine with its counters, brightness
// register and registered PWM light output.
module key_light_channel
  import key_light_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES      = 25000000,
  parameter int unsigned FADE_STEP_CYCLES = 1562500,
  parameter int unsigned PWM_BITS         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit,
  input  logic                mode,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                light,
  output logic                active
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(bright_max(PWM_BITS));
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned STEP_W = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(FADE_STEP_CYCLES - 1);

  chan_state_t         state, state_next;
  logic [PWM_BITS-1:0] bright, bright_next;
  logic [HOLD_W-1:0]   hold_cnt, hold_next;
  logic [STEP_W-1:0]   step_cnt, step_next;
  logic                light_d, active_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bright   <= '0;
      hold_cnt <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_next;
      bright   <= bright_next;
      hold_cnt <= hold_next;
      step_cnt <= step_next;
    end
  end

  // Disable beats a press; a press beats everything else; leaving sustain
  // mode without a press drops the channel straight to IDLE.
  always_comb begin
    state_next  = state;
    bright_next = bright;
    hold_next   = hold_cnt;
    step_next   = step_cnt;
    if (!enable) begin
      state_next  = IDLE;
      bright_next = '0;
    end else if (hit) begin
      state_next  = PRESSED;
      bright_next = MAX;
    end else if (!mode) begin
      state_next  = IDLE;
      bright_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          bright_next = '0;
        end
        PRESSED: begin
          state_next  = HOLD;
          bright_next = MAX;
          hold_next   = HOLD_LOAD;
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            // A 1-bit brightness has no intermediate fade levels.
            if (MAX > PWM_BITS'(1)) begin
              state_next  = FADE;
              bright_next = MAX - PWM_BITS'(1);
              step_next   = STEP_LOAD;
            end else begin
              state_next  = IDLE;
              bright_next = '0;
            end
          end else begin
            hold_next = hold_cnt - HOLD_W'(1);
          end
        end
        FADE: begin
          if (step_cnt == '0) begin
            if (bright == PWM_BITS'(1)) begin
              state_next  = IDLE;
              bright_next = '0;
            end else begin
              bright_next = bright - PWM_BITS'(1);
              step_next   = STEP_LOAD;
            end
          end else begin
            step_next = step_cnt - STEP_W'(1);
          end
        end
        default: begin
          state_next  = IDLE;
          bright_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    light_d  = (bright == MAX) || (pwm_cnt < bright);
    active_d = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light  <= 1'b0;
      active <= 1'b0;
    end else begin
      light  <= light_d;
      active <= active_d;
    end
  end

endmodule

// File: rtl/key_light_array.sv
// Multi-key light driver: registered note decode, shared PWM counter and one
// sustain/fade channel per key.
module key_light_array
  import key_light_pkg::*;
#(
  parameter int unsigned NUM_KEYS         = 8,
  parameter int unsigned CODE_W           = 8,
  parameter int unsigned BASE_CODE        = 1,
  parameter int unsigned REST_CODE        = REST_CODE_DEFAULT,
  parameter int unsigned HOLD_CYCLES      = 25000000,
  parameter int unsigned FADE_STEP_CYCLES = 1562500,
  parameter int unsigned PWM_BITS         = 4
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic [CODE_W-1:0]   iNote,
  input  logic                iMode,
  input  logic                iEnable,
  output logic [NUM_KEYS-1:0] oLights,
  output logic                oActive
);

  logic [NUM_KEYS-1:0] hit_d, hit_q, active;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [31:0]         note_ext;
  logic                code_ok;

  // Key codes are compared zero-extended so BASE_CODE+k never wraps.
  always_comb begin
    note_ext = 32'(iNote);
    code_ok  = (note_ext != 32'd0) && (note_ext != REST_CODE);
    hit_d    = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      hit_d[k] = iEnable && code_ok && (note_ext == BASE_CODE + k);
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      hit_q   <= '0;
      pwm_cnt <= '0;
    end else begin
      hit_q   <= hit_d;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_light_channel #(
      .HOLD_CYCLES      (HOLD_CYCLES),
      .FADE_STEP_CYCLES (FADE_STEP_CYCLES),
      .PWM_BITS         (PWM_BITS)
    ) u_chan (
      .clk     (iClk),
      .rst_n   (iReset_n),
      .hit     (hit_q[k]),
      .mode    (iMode),
      .enable  (iEnable),
      .pwm_cnt (pwm_cnt),
      .light   (oLights[k]),
      .active  (active[k])
    );
  end

  assign oActive = |active;

endmodule

// File: tb/tb_key_light_array.sv
// Bench for key_light_array: directed vector table, async reset sequence and
// randomized traffic against an elapsed-time brightness model.
module tb_key_light_array;

  localparam int NK   = 4;
  localparam int HOLD = 5;
  localparam int STEP = 2;
  localparam int MAXB = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] note  = 8'd0;
  logic       mode  = 1'b0;
  logic       en    = 1'b1;
  logic [3:0] lights;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_light_array #(
    .NUM_KEYS         (NK),
    .CODE_W           (8),
    .BASE_CODE        (1),
    .REST_CODE        (99),
    .HOLD_CYCLES      (HOLD),
    .FADE_STEP_CYCLES (STEP),
    .PWM_BITS         (2)
  ) dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .iNote    (note),
    .iMode    (mode),
    .iEnable  (en),
    .oLights  (lights),
    .oActive  (active)
  );

  // Reference model: age = -1 idle, 0 while held, n = n-th cycle after release.
  int         age [NK];
  logic [3:0] mhq;
  int         mpwm;
  logic [3:0] m_lights;
  logic       m_active;

  function automatic int bright_of(input int a);
    if (a < 0) return 0;
    if (a <= HOLD) return MAXB;
    return MAXB - 1 - (a - HOLD - 1) / STEP;
  endfunction

  function automatic int next_age(input int a, input logic hq, input logic e, input logic m);
    if (!e) return -1;
    if (hq) return 0;
    if (!m) return -1;
    if (a < 0) return -1;
    if (a + 1 > HOLD + (MAXB - 1) * STEP) return -1;
    return a + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) age[k] <= -1;
      mhq      <= '0;
      mpwm     <= 0;
      m_lights <= '0;
      m_active <= 1'b0;
    end else begin
      for (int k = 0; k < NK; k++) begin
        m_lights[k] <= (bright_of(age[k]) == MAXB) || (mpwm < bright_of(age[k]));
        age[k]      <= next_age(age[k], mhq[k], en, mode);
        mhq[k]      <= en && (note != 8'd0) && (note != 8'd99) && (int'(note) == 1 + k);
      end
      m_active <= (age[0] >= 0) || (age[1] >= 0) || (age[2] >= 0) || (age[3] >= 0);
      mpwm     <= (mpwm + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         do_reset;
    logic [7:0] note;
    bit         mode;
    bit         en;
    logic [3:0] exp_lights;
    bit         exp_active;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input logic [7:0] n, input bit m, input bit e,
                              input logic [3:0] l, input bit a);
    vec_t v;
    v.do_reset = r; v.note = n; v.mode = m; v.en = e; v.exp_lights = l; v.exp_active = a;
    vecs.push_back(v);
  endfunction

  logic [13:0] sus_l, sus_a;
  logic [21:0] ret_l, ret_a;

  initial begin
    // Rest / out-of-range codes never light anything.
    add(1, 8'd0,  1, 1, 4'b0000, 0);
    add(0, 8'd99, 1, 1, 4'b0000, 0);
    add(0, 8'd7,  1, 1, 4'b0000, 0);
    add(0, 8'd5,  1, 1, 4'b0000, 0);
    add(0, 8'd0,  1, 1, 4'b0000, 0);
    add(0, 8'd0,  1, 1, 4'b0000, 0);
    // Direct mode: code 3 -> key 2.
    add(1, 8'd3, 0, 1, 4'b0000, 0);
    add(0, 8'd3, 0, 1, 4'b0000, 0);
    add(0, 8'd3, 0, 1, 4'b0100, 1);
    add(0, 8'd3, 0, 1, 4'b0100, 1);
    add(0, 8'd0, 0, 1, 4'b0100, 1);
    add(0, 8'd0, 0, 1, 4'b0100, 1);
    add(0, 8'd0, 0, 1, 4'b0000, 0);
    // Sustain timing on key 0 (PWM phase known from the reset).
    sus_l = 14'b01001111111100;
    sus_a = 14'b01111111111100;
    for (int e = 0; e < 14; e++)
      add(e == 0, (e < 2) ? 8'd1 : 8'd0, 1, 1, {3'b000, sus_l[e]}, sus_a[e]);
    // Retrigger during fade, hold restarts at full length.
    ret_l = 22'b0100111111101111111100;
    ret_a = 22'b0111111111111111111100;
    for (int e = 0; e < 22; e++)
      add(e == 0, (e < 2 || e == 9) ? 8'd1 : 8'd0, 1, 1, {3'b000, ret_l[e]}, ret_a[e]);
    // Key switch 2 -> 4 in sustain.
    add(1, 8'd2, 1, 1, 4'b0000, 0);
    add(0, 8'd2, 1, 1, 4'b0000, 0);
    add(0, 8'd4, 1, 1, 4'b0010, 1);
    add(0, 8'd4, 1, 1, 4'b0010, 1);
    add(0, 8'd0, 1, 1, 4'b1010, 1);
    add(0, 8'd0, 1, 1, 4'b1010, 1);
    add(0, 8'd0, 1, 1, 4'b1010, 1);
    // Mode drop during HOLD.
    add(1, 8'd2, 1, 1, 4'b0000, 0);
    add(0, 8'd2, 1, 1, 4'b0000, 0);
    add(0, 8'd0, 1, 1, 4'b0010, 1);
    add(0, 8'd0, 1, 1, 4'b0010, 1);
    add(0, 8'd0, 1, 1, 4'b0010, 1);
    add(0, 8'd0, 0, 1, 4'b0010, 1);
    add(0, 8'd0, 0, 1, 4'b0000, 0);
    // Enable drop while key held.
    add(1, 8'd2, 1, 1, 4'b0000, 0);
    add(0, 8'd2, 1, 1, 4'b0000, 0);
    add(0, 8'd2, 1, 1, 4'b0010, 1);
    add(0, 8'd2, 1, 1, 4'b0010, 1);
    add(0, 8'd2, 1, 0, 4'b0010, 1);
    add(0, 8'd2, 1, 0, 4'b0000, 0);
    add(0, 8'd2, 1, 0, 4'b0000, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_lights", 32'(lights), 32'd0);
    check("reset_active", 32'(active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].do_reset) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      note = vecs[i].note;
      mode = vecs[i].mode;
      en   = vecs[i].en;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_lights", i), 32'(lights), 32'(vecs[i].exp_lights));
      check($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].exp_active));
    end

    // Asynchronous reset mid-cycle while a key is lit.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    note = 8'd1; mode = 1'b0; en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_async_lights", 32'(lights), 32'h1);
    check("pre_async_active", 32'(active), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_lights", 32'(lights), 32'd0);
    check("async_rst_active", 32'(active), 32'd0);
    @(negedge clk);
    note = 8'd0;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) begin
        int r;
        r = int'($urandom_range(9));
        if (r <= 5)      note = 8'(r);
        else if (r == 6) note = 8'd99;
        else if (r == 7) note = 8'd0;
        else             note = 8'($urandom_range(255));
      end
      mode = ($urandom_range(15) != 0);
      en   = ($urandom_range(31) != 0);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_lights", c), 32'(lights), 32'(m_lights));
      check($sformatf("rand%0d_active", c), 32'(active), 32'(m_active));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
